// File: rtl/ic_hc_p2s_controller_if.sv
// Handshake and data bundle between the block buffer, the P2S controller and
// the serializer / Huffman coder. The controller uses the master modport.
interface ic_hc_p2s_controller_if #(
    parameter int MCU_W = 16
);
    logic             start;
    logic [MCU_W-1:0] num_mcu;
    logic             blk_ready;
    logic             rd_req;
    logic [2:0]       rd_addr;
    logic             rd_valid;
    logic [103:0]     rd_data;
    logic             hc_ready;
    logic             p2s_enable;
    logic [2:0]       p2s_diff_enable;
    logic [103:0]     p2s_readdata;
    logic [1:0]       comp_id;
    logic             blk_ack;
    logic             busy;
    logic             done;

    modport master (
        input  start, num_mcu, blk_ready, rd_valid, rd_data, hc_ready,
        output rd_req, rd_addr, p2s_enable, p2s_diff_enable, p2s_readdata,
               comp_id, blk_ack, busy, done
    );

    modport slave (
        output start, num_mcu, blk_ready, rd_valid, rd_data, hc_ready,
        input  rd_req, rd_addr, p2s_enable, p2s_diff_enable, p2s_readdata,
               comp_id, blk_ack, busy, done
    );
endinterface

// File: rtl/ic_hc_p2s_controller.sv
// Fetches 8 words per 8x8 block and feeds each to the serializer as a 16-cycle burst.
// Define IC_HC_CHROMA_420_EN for 4:2:0 MCUs (Y,Y,Y,Y,Cb,Cr); default is 4:4:4 (Y,Cb,Cr).
module ic_hc_p2s_controller #(
    parameter int MCU_W = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    ic_hc_p2s_controller_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BLK,
        REQ,
        WAIT_DATA,
        HOLD,
        SERIAL
    } state_t;

`ifdef IC_HC_CHROMA_420_EN
    localparam logic [2:0] BLK_LAST = 3'd5;
`else
    localparam logic [2:0] BLK_LAST = 3'd2;
`endif

    function automatic logic [1:0] comp_of(input logic [2:0] blk);
`ifdef IC_HC_CHROMA_420_EN
        if (blk == 3'd4)      return 2'd1;
        else if (blk == 3'd5) return 2'd2;
        else                  return 2'd0;
`else
        return blk[1:0];
`endif
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       word_q, word_d;
    logic [2:0]       blk_q, blk_d;
    logic [MCU_W-1:0] mcu_q, mcu_d;
    logic [MCU_W-1:0] num_q, num_d;
    logic [3:0]       ser_q, ser_d;
    logic             load;
    logic             ack_d;
    logic             done_d;
    logic [2:0]       diff_d;

    logic             rd_req_q;
    logic             en_q;
    logic [2:0]       diff_q;
    logic [103:0]     readdata_q;
    logic [1:0]       comp_q;
    logic             ack_q;
    logic             busy_q;
    logic             done_q;

    // Next-state logic; pulse outputs are computed on the transition so their
    // registered versions line up with the state they describe.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        blk_d   = blk_q;
        mcu_d   = mcu_q;
        num_d   = num_q;
        ser_d   = ser_q;
        load    = 1'b0;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        diff_d  = 3'b000;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    num_d  = bus.num_mcu;
                    word_d = 3'd0;
                    blk_d  = 3'd0;
                    mcu_d  = '0;
                    if (bus.num_mcu == '0) done_d = 1'b1;
                    else                   state_d = WAIT_BLK;
                end
            end
            WAIT_BLK: begin
                if (bus.blk_ready) state_d = REQ;
            end
            REQ: begin
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (bus.rd_valid) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.hc_ready) begin
                    state_d = SERIAL;
                    ser_d   = 4'd0;
                    if (word_q == 3'd0) diff_d = 3'b001 << comp_of(blk_q);
                end
            end
            SERIAL: begin
                ser_d = ser_q + 4'd1;
                if (ser_q == 4'd15) begin
                    if (word_q != 3'd7) begin
                        word_d  = word_q + 3'd1;
                        state_d = REQ;
                    end else begin
                        ack_d  = 1'b1;
                        word_d = 3'd0;
                        if (blk_q == BLK_LAST) begin
                            blk_d = 3'd0;
                            mcu_d = mcu_q + 1'b1;
                            if (mcu_q + 1'b1 == num_q) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end else begin
                                state_d = WAIT_BLK;
                            end
                        end else begin
                            blk_d   = blk_q + 3'd1;
                            state_d = WAIT_BLK;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            word_q     <= 3'd0;
            blk_q      <= 3'd0;
            mcu_q      <= '0;
            num_q      <= '0;
            ser_q      <= 4'd0;
            rd_req_q   <= 1'b0;
            en_q       <= 1'b0;
            diff_q     <= 3'b000;
            readdata_q <= '0;
            comp_q     <= 2'd0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            blk_q    <= blk_d;
            mcu_q    <= mcu_d;
            num_q    <= num_d;
            ser_q    <= ser_d;
            rd_req_q <= (state_d == REQ);
            en_q     <= (state_d == SERIAL);
            diff_q   <= diff_d;
            comp_q   <= comp_of(blk_d);
            ack_q    <= ack_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= done_d;
            if (load) readdata_q <= bus.rd_data;
        end
    end

    assign bus.rd_req          = rd_req_q;
    assign bus.rd_addr         = word_q;
    assign bus.p2s_enable      = en_q;
    assign bus.p2s_diff_enable = diff_q;
    assign bus.p2s_readdata    = readdata_q;
    assign bus.comp_id         = comp_q;
    assign bus.blk_ack         = ack_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;

endmodule
